hamming74_frame_decoder: RTL and testbench

//  Receive-side stage directly downstream of the FSK demodulator. Consumes the recovered serial
//  bit stream, hunts for the frame sync word, deserializes Hamming(7,4) codewords, corrects

---
 rtl/hamming74_frame_decoder.sv | 171 +++++++++++++++++
 tb/tb_hamming74_frame_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_frame_decoder.sv
// Hamming(7,4) frame decoder.
// Hunts the demodulated bit stream for the frame sync word, then deserializes
// CW_PER_FRAME codewords, corrects single-bit errors and emits one nibble per
// codeword. A saturating counter tracks how many codewords needed correction.
module hamming74_frame_decoder #(
    parameter logic [15:0] SYNC_WORD    = 16'b1010_1101,
    parameter int          SYNC_LEN     = 8,
    parameter int          CW_PER_FRAME = 4,
    parameter int          ERR_CNT_W    = 8
) (
    input  logic                 sys_clock,
    input  logic                 reset_original,
    input  logic                 io_bit_in,
    input  logic                 io_bit_valid,
    output logic [3:0]           io_output,
    output logic                 io_data_valid,
    output logic                 io_corrected,
    output logic                 io_frame_done,
    output logic                 io_locked,
    output logic [ERR_CNT_W-1:0] io_err_count
);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CW = 8'(CW_PER_FRAME - 1);

    state_t                 state_q,   state_d;
    logic [SYNC_LEN-1:0]    sync_q,    sync_d;
    logic [5:0]             cw_q,      cw_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             cw_cnt_q,  cw_cnt_d;
    logic [3:0]             out_q,     out_d;
    logic                   dv_q,      dv_d;
    logic                   corr_q,    corr_d;
    logic                   fd_q,      fd_d;
    logic [ERR_CNT_W-1:0]   err_q,     err_d;

    logic [SYNC_LEN:0]      sync_ext;
    logic [SYNC_LEN-1:0]    sync_shift;
    logic [4:0]             dec;

    // Decode a full codeword, vector bit 6 = c1 ... bit 0 = c7.
    // Returns {syndrome_nonzero, d3, d2, d1, d0}.
    function automatic logic [4:0] decode_cw(input logic [6:0] cw);
        logic       s1, s2, s4;
        logic [2:0] syn;
        logic [2:0] idx;
        logic [6:0] fixed;
        s1    = cw[6] ^ cw[4] ^ cw[2] ^ cw[0];
        s2    = cw[5] ^ cw[4] ^ cw[1] ^ cw[0];
        s4    = cw[3] ^ cw[2] ^ cw[1] ^ cw[0];
        syn   = {s4, s2, s1};
        fixed = cw;
        idx   = 3'd7 - syn;
        if (syn != 3'd0) begin
            fixed[idx] = ~fixed[idx];
        end
        // Data bits are c3, c5, c6, c7.
        return {(syn != 3'd0), fixed[4], fixed[2], fixed[1], fixed[0]};
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + ERR_CNT_W'(1);
    endfunction

    assign sync_ext   = {sync_q, io_bit_in};
    assign sync_shift = sync_ext[SYNC_LEN-1:0];
    assign dec        = decode_cw({cw_q, io_bit_in});

    // Next-state logic: sync hunt, codeword deserialization and decode.
    always_comb begin
        state_d   = state_q;
        sync_d    = sync_q;
        cw_d      = cw_q;
        bit_cnt_d = bit_cnt_q;
        cw_cnt_d  = cw_cnt_q;
        out_d     = out_q;
        dv_d      = 1'b0;
        corr_d    = 1'b0;
        fd_d      = 1'b0;
        err_d     = err_q;

        case (state_q)
            HUNT: begin
                if (io_bit_valid) begin
                    if (sync_shift == SYNC_WORD[SYNC_LEN-1:0]) begin
                        // Clearing the sync register keeps payload bits from
                        // combining with the sync word later on.
                        state_d   = RECV;
                        sync_d    = '0;
                        bit_cnt_d = 3'd0;
                        cw_cnt_d  = 8'd0;
                        cw_d      = 6'd0;
                    end else begin
                        sync_d = sync_shift;
                    end
                end
            end
            RECV: begin
                if (io_bit_valid) begin
                    if (bit_cnt_q == 3'd6) begin
                        out_d     = dec[3:0];
                        dv_d      = 1'b1;
                        corr_d    = dec[4];
                        if (dec[4]) begin
                            err_d = sat_inc(err_q);
                        end
                        bit_cnt_d = 3'd0;
                        cw_d      = 6'd0;
                        if (cw_cnt_q == LAST_CW) begin
                            fd_d     = 1'b1;
                            state_d  = HUNT;
                            cw_cnt_d = 8'd0;
                            sync_d   = '0;
                        end else begin
                            cw_cnt_d = cw_cnt_q + 8'd1;
                        end
                    end else begin
                        cw_d      = {cw_q[4:0], io_bit_in};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge sys_clock) begin
        if (!reset_original) begin
            state_q   <= HUNT;
            sync_q    <= '0;
            cw_q      <= 6'd0;
            bit_cnt_q <= 3'd0;
            cw_cnt_q  <= 8'd0;
            out_q     <= 4'd0;
            dv_q      <= 1'b0;
            corr_q    <= 1'b0;
            fd_q      <= 1'b0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            cw_q      <= cw_d;
            bit_cnt_q <= bit_cnt_d;
            cw_cnt_q  <= cw_cnt_d;
            out_q     <= out_d;
            dv_q      <= dv_d;
            corr_q    <= corr_d;
            fd_q      <= fd_d;
            err_q     <= err_d;
        end
    end

    assign io_output     = out_q;
    assign io_data_valid = dv_q;
    assign io_corrected  = corr_q;
    assign io_frame_done = fd_q;
    assign io_locked     = (state_q == RECV);
    assign io_err_count  = err_q;

endmodule

// File: tb/tb_hamming74_frame_decoder.sv
// Self-checking bench for hamming74_frame_decoder: directed codeword tables
// plus hand-written reset, sync-hunt and saturation sequences.
module tb_hamming74_frame_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_vld = 1'b0;

    logic [3:0] out0, out1;
    logic       dv0, dv1, corr0, corr1, fd0, fd1, lk0, lk1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;

    int checks = 0;
    int errors = 0;
    int exp_err0 = 0;
    int exp_err1 = 0;

    always #5 clk = ~clk;

    hamming74_frame_decoder dut0 (
        .sys_clock      (clk),
        .reset_original (rst_n),
        .io_bit_in      (bit_in),
        .io_bit_valid   (bit_vld),
        .io_output      (out0),
        .io_data_valid  (dv0),
        .io_corrected   (corr0),
        .io_frame_done  (fd0),
        .io_locked      (lk0),
        .io_err_count   (cnt0)
    );

    hamming74_frame_decoder #(.ERR_CNT_W(2)) dut1 (
        .sys_clock      (clk),
        .reset_original (rst_n),
        .io_bit_in      (bit_in),
        .io_bit_valid   (bit_vld),
        .io_output      (out1),
        .io_data_valid  (dv1),
        .io_corrected   (corr1),
        .io_frame_done  (fd1),
        .io_locked      (lk1),
        .io_err_count   (cnt1)
    );

    typedef struct {
        logic [6:0] cw;       // c1..c7, c1 in bit 6
        int         flip;     // position to invert, 0 = none
        logic [3:0] exp_nib;
        logic       exp_corr;
    } vec_t;

    typedef struct {
        logic [3:0] nib;
        logic       corr;
        logic       done;
        logic [7:0] c0;
        logic [1:0] c1;
    } rec_t;

    vec_t vecs[12];
    rec_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Capture every output pulse; both instances must agree on pulses.
    always @(negedge clk) begin
        if (dv0 || dv1) begin
            check("dut_agree", {27'd0, dv1, out1, corr1, fd1, lk1}, {27'd0, dv0, out0, corr0, fd0, lk0});
            if (dv0) q.push_back('{out0, corr0, fd0, cnt0, cnt1});
        end
    end

    task automatic send_bit(input logic b, input int gapmax);
        int g;
        @(negedge clk);
        bit_in  = b;
        bit_vld = 1'b1;
        g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        for (int k = 0; k < g; k++) begin
            @(negedge clk);
            bit_vld = 1'b0;
            bit_in  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            bit_vld = 1'b0;
        end
    endtask

    task automatic send_sync(input int gapmax);
        logic [7:0] sw;
        sw = 8'b1010_1101;
        for (int k = 7; k >= 0; k--) send_bit(sw[k], gapmax);
        @(negedge clk);
        bit_vld = 1'b0;
        check("locked_after_sync", {31'd0, lk0}, 32'd1);
    endtask

    task automatic send_cw(input vec_t v, input int gapmax);
        logic [6:0] cw;
        logic [6:0] mask;
        mask = 7'b1000000;
        cw   = v.cw;
        if (v.flip > 0) cw = cw ^ (mask >> (v.flip - 1));
        for (int k = 6; k >= 0; k--) send_bit(cw[k], gapmax);
    endtask

    task automatic run_frame(input int first, input int n, input int gapmax);
        rec_t r;
        vec_t v;
        for (int i = 0; i < n; i++) begin
            if (i % 4 == 0) send_sync(gapmax);
            send_cw(vecs[first + i], gapmax);
        end
        idle(3);
        check("pulse_count", q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (q.size() == 0) break;
            r = q.pop_front();
            v = vecs[first + i];
            if (v.exp_corr) begin
                if (exp_err0 < 255) exp_err0++;
                if (exp_err1 < 3) exp_err1++;
            end
            check("nibble", {28'd0, r.nib}, {28'd0, v.exp_nib});
            check("corrected", {31'd0, r.corr}, {31'd0, v.exp_corr});
            check("frame_done", {31'd0, r.done}, (i % 4 == 3) ? 32'd1 : 32'd0);
            check("err_count", {24'd0, r.c0}, exp_err0);
            check("err_count_w2", {30'd0, r.c1}, exp_err1);
        end
        q.delete();
    endtask

    initial begin
        vecs[0] = '{7'b0110011, 0, 4'b1011, 1'b0};
        vecs[1] = '{7'b0000000, 0, 4'b0000, 1'b0};
        vecs[2] = '{7'b1111111, 0, 4'b1111, 1'b0};
        vecs[3] = '{7'b1100110, 0, 4'b0110, 1'b0};
        vecs[4] = '{7'b0110011, 5, 4'b1011, 1'b1};
        for (int p = 1; p <= 7; p++) vecs[4 + p] = '{7'b0110011, p, 4'b1011, 1'b1};

        // Reset held for 3 cycles with random valid bits.
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bit_in  = 1'($urandom_range(0, 1));
            bit_vld = 1'b1;
            check("rst_output", {28'd0, out0}, 32'd0);
            check("rst_pulses", {29'd0, dv0, corr0, fd0}, 32'd0);
            check("rst_locked", {31'd0, lk0}, 32'd0);
            check("rst_err", {24'd0, cnt0}, 32'd0);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        bit_vld = 1'b0;
        for (int k = 0; k < 12; k++) send_bit(1'b0, 0);
        idle(3);
        check("no_pulse_without_sync", q.size(), 0);
        check("unlocked_without_sync", {31'd0, lk0}, 32'd0);
        q.delete();

        // Clean frame, then single-bit errors across two frames.
        run_frame(0, 4, 0);
        check("unlocked_after_frame", {31'd0, lk0}, 32'd0);
        run_frame(4, 8, 0);

        // False prefix and random gaps between bits.
        send_bit(1'b1, 3);
        send_bit(1'b1, 3);
        check("prefix_not_locked", {31'd0, lk0}, 32'd0);
        run_frame(0, 4, 3);

        // Reset after bit 4 of codeword 2.
        send_sync(0);
        send_cw(vecs[0], 0);
        for (int k = 6; k >= 3; k--) send_bit(vecs[1].cw[k], 0);
        @(negedge clk);
        rst_n   = 1'b0;
        bit_vld = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(4);
        check("midframe_pulses", q.size(), 1);
        check("midframe_err_clr", {24'd0, cnt0}, 32'd0);
        check("midframe_out_clr", {28'd0, out0}, 32'd0);
        check("midframe_unlocked", {31'd0, lk0}, 32'd0);
        q.delete();
        exp_err0 = 0;
        exp_err1 = 0;
        run_frame(0, 4, 0);

        // Saturation: five corrected codewords, counts 1,2,3,3,3 on the 2-bit counter.
        run_frame(4, 5, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
